mtrx_writeback: RTL and testbench

MTRX_WRITEBACK -- requirements
Module: mtrx_writeback

---
 rtl/mtrx_writeback.sv | 108 ++++++++++
 tb/tb_mtrx_writeback.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mtrx_writeback.sv
// Purpose: writes a captured 5x5 matrix of signed bytes to memory, one element per transfer, ascending address.
// Latency: first write 1 cycle after start; done 26 cycles after start when memory never stalls.
// Backpressure: mem_ready low holds address/data and index; stalls may last indefinitely.
module mtrx_writeback #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [199:0]          matrix,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  mem_ready,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [4:0] LAST_IDX = 5'd24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            idx_q, idx_d;
  logic [199:0]          mat_q, mat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  // Current element sits in the low byte once the captured matrix is shifted by index*8.
  logic [199:0]          mat_shift;
  assign mat_shift = mat_q >> {idx_q, 3'b000};

  // State, index and captured job registers; reset abandons any job in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mat_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mat_q   <= mat_d;
      base_q  <= base_d;
    end
  end

  // Next-state logic: capture on start in IDLE, advance only on accepted transfers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mat_d   = mat_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mat_d   = matrix;
          base_d  = base_addr;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so reset clears them immediately
  // and address/data cannot move while the memory stalls.
  always_comb begin
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      WRITE: begin
        mem_wr   = 1'b1;
        mem_addr = base_q + ADDR_WIDTH'(idx_q);
        mem_data = mat_shift[7:0];
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mtrx_writeback.sv
// Purpose: directed bench for mtrx_writeback covering basic, stalled, wrapping, isolated, reset and negative-data jobs.
// Latency: expects first write one cycle after start and done at cycle 26 (50 with alternate-cycle stalls).
// Backpressure: drives mem_ready from the bench, checks address/data holding during stalls.
module tb_mtrx_writeback;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [199:0] matrix;
  logic [7:0]   base_addr;
  logic         mem_ready;
  logic         mem_wr;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_data;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mtrx_writeback #(.ADDR_WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .matrix    (matrix),
    .base_addr (base_addr),
    .mem_ready (mem_ready),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Element i = i+2.
  function automatic logic [199:0] ramp_matrix();
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(i + 2);
    return m;
  endfunction

  // Subtractor-style negative results first, then other high-bit bytes.
  function automatic logic [199:0] neg_matrix();
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(8'h80 + i);
    m[0*8 +: 8] = 8'hFF;
    m[1*8 +: 8] = 8'hFD;
    m[2*8 +: 8] = 8'hE9;
    return m;
  endfunction

  // One job: start at a falling edge, then observe every falling edge until done.
  task automatic run_job(input logic [199:0] m, input logic [7:0] b, input bit stall, input bit disturb);
    int         n;
    int         ndone;
    int         done_cyc;
    bit         stalled;
    logic [7:0] prev_a;
    logic [7:0] prev_d;
    @(negedge clock);
    chk("idle_wr", mem_wr, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    matrix    = m;
    base_addr = b;
    start     = 1'b1;
    mem_ready = 1'b1;
    n         = 0;
    ndone     = 0;
    done_cyc  = -1;
    stalled   = 1'b0;
    prev_a    = '0;
    prev_d    = '0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clock);
      start = disturb && (cyc == 5);
      if (disturb && cyc == 5) begin
        matrix    = ~m;
        base_addr = b + 8'h40;
      end
      mem_ready = stall ? (cyc % 2 == 1) : 1'b1;
      if (cyc == 1) chk("first_wr_latency", mem_wr, 1'b1);
      if (mem_wr) begin
        chk("busy_in_write", busy, 1'b1);
        if (stalled) begin
          chk("hold_addr", mem_addr, prev_a);
          chk("hold_data", mem_data, prev_d);
        end
        if (n < 25) begin
          chk($sformatf("addr%0d", n), mem_addr, 8'(b + n));
          chk($sformatf("data%0d", n), mem_data, m[n*8 +: 8]);
        end else begin
          chk("extra_write", n, 24);
        end
        stalled = !mem_ready;
        prev_a  = mem_addr;
        prev_d  = mem_data;
        if (mem_ready) n++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk("busy_in_done", busy, 1'b0);
        chk("wr_in_done", mem_wr, 1'b0);
        chk("addr_in_done", mem_addr, 8'h00);
        chk("data_in_done", mem_data, 8'h00);
      end
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    chk("n_writes", n, 25);
    chk("n_done", ndone, 1);
    chk("done_cycle", done_cyc, stall ? 50 : 26);
  endtask

  initial begin
    logic [199:0] ramp;
    reset     = 1'b1;
    start     = 1'b0;
    matrix    = '0;
    base_addr = '0;
    mem_ready = 1'b0;
    ramp      = ramp_matrix();
    #1;
    chk("rst_wr", mem_wr, 1'b0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_data", mem_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Basic job, then an immediate back-to-back stalled job (27-cycle period).
    run_job(ramp, 8'h10, 1'b0, 1'b0);
    run_job(ramp, 8'h10, 1'b1, 1'b0);
    // Address wrap FA..FF, 00..12.
    run_job(ramp, 8'hFA, 1'b0, 1'b0);
    // Inputs changed and start re-pulsed mid-job.
    run_job(ramp, 8'h10, 1'b0, 1'b1);
    // Negative data bytes pass through unchanged.
    run_job(neg_matrix(), 8'h30, 1'b0, 1'b0);

    // Reset after 10 transfers.
    @(negedge clock);
    matrix    = ramp;
    base_addr = 8'h10;
    start     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    chk("pre_rst_addr", mem_addr, 8'h1A);
    chk("pre_rst_data", mem_data, 8'h0C);
    reset = 1'b1;
    start = 1'b1;
    #1;
    chk("midrst_wr", mem_wr, 1'b0);
    chk("midrst_addr", mem_addr, 8'h00);
    chk("midrst_data", mem_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("inrst_wr", mem_wr, 1'b0);
      chk("inrst_done", done, 1'b0);
    end
    start = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("postrst_wr", mem_wr, 1'b0);
      chk("postrst_done", done, 1'b0);
    end
    run_job(ramp, 8'h10, 1'b0, 1'b0);

    @(negedge clock);
    chk("final_done", done, 1'b0);
    chk("final_busy", busy, 1'b0);
    chk("final_wr", mem_wr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
